// File: rtl/plic_pkg.sv
// Shared types for the PLIC interrupt gateway: source modes, per-source
// FSM states and the synchroniser depth ceiling.
package plic_pkg;

    // Deepest input synchroniser a cell will build.
    localparam int SYNC_STAGES_MAX = 3;

    // Per-source trigger mode (raw encoding 2'b11 folds onto level).
    typedef enum logic [1:0] {
        MODE_LEVEL    = 2'b00,
        MODE_EDGE     = 2'b01,
        MODE_EDGE_CNT = 2'b10
    } plic_mode_e;

    // Gateway FSM: waiting, pending towards targets, in service.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_SERV = 2'b10
    } plic_state_e;

    // Map the raw mode field onto the enum; the reserved code is level.
    function automatic plic_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_EDGE;
            2'b10:   return MODE_EDGE_CNT;
            default: return MODE_LEVEL;
        endcase
    endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// Single-source gateway: input synchroniser, rise detector, saturating
// pending-edge counter with sticky overflow, and the IDLE/PEND/SERV FSM.
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       src_i,
    input  logic [1:0] mode_i,
    input  logic       claim_i,
    input  logic       complete_i,
    input  logic       ovf_clr_i,
    output logic       ip_o,
    output logic       ia_o,
    output logic       ovf_o
);

    // Depth actually built, clamped to the supported range.
    localparam int SS = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                        (SYNC_STAGES < 0)               ? 0 : SYNC_STAGES;

    logic        s;
    logic        s_prev_d, s_prev_q;
    logic        rise;
    plic_mode_e  mode_d, mode_q;
    logic        mode_chg;
    logic        is_edge;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic        inc, dec;
    logic        ovf_evt;
    logic        ovf_d, ovf_q;
    plic_state_e state_d, state_q;

    generate
        if (SS == 0) begin : g_bypass
            assign s = src_i;
        end else begin : g_sync
            logic [SS-1:0] sync_d, sync_q;

            // Shift the raw line through the synchroniser chain.
            always_comb begin
                sync_d = SS'({sync_q, src_i});
            end

            // Synchroniser flops, cleared on reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sync_q <= '0;
                else         sync_q <= sync_d;
            end

            assign s = sync_q[SS-1];
        end
    endgenerate

    assign rise     = s & ~s_prev_q;
    assign s_prev_d = s;

    // Registered mode; any change of the decoded mode flushes the counter.
    assign mode_d   = decode_mode(mode_i);
    assign mode_chg = (mode_d != mode_q);
    assign is_edge  = (mode_q != MODE_LEVEL);

    // Plain edge mode remembers at most one edge; edge-count fills the counter.
    assign lim = (mode_q == MODE_EDGE_CNT) ? '1 : CNT_W'(1);

    assign inc = is_edge & rise;
    assign dec = is_edge & claim_i & (state_q == ST_PEND);

    // Saturating pending-edge counter; a coincident rise and claim cancel.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_evt = 1'b0;
        if (mode_chg) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q >= lim) ovf_evt = (mode_q == MODE_EDGE_CNT);
            else              cnt_d   = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    // Sticky overflow; a new overflow beats a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (ovf_evt)   ovf_d = 1'b1;
    end

    // Gateway FSM; claim only acts in PEND, complete only in SERV.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (is_edge ? ((cnt_q != '0) || rise) : s) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (claim_i) state_d = ST_SERV;
            end
            ST_SERV: begin
                if (complete_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State flops; reset drops any in-service and counted edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_prev_q <= 1'b0;
            mode_q   <= MODE_LEVEL;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            s_prev_q <= s_prev_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    assign ip_o  = (state_q == ST_PEND);
    assign ia_o  = (state_q == ST_SERV);
    assign ovf_o = ovf_q;

endmodule

// File: rtl/plic_gateway_v2.sv
// PLIC gateway array: one independent gateway cell per interrupt source.
module plic_gateway_v2
    import plic_pkg::*;
#(
    parameter int N_SOURCE    = 64,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_SOURCE-1:0]      src_i,
    input  logic [N_SOURCE-1:0][1:0] mode_i,
    input  logic [N_SOURCE-1:0]      claim_i,
    input  logic [N_SOURCE-1:0]      complete_i,
    input  logic [N_SOURCE-1:0]      ovf_clr_i,
    output logic [N_SOURCE-1:0]      ip_o,
    output logic [N_SOURCE-1:0]      ia_o,
    output logic [N_SOURCE-1:0]      ovf_o
);

    generate
        for (genvar i = 0; i < N_SOURCE; i++) begin : g_cell
            plic_gateway_cell #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cell (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .src_i      (src_i[i]),
                .mode_i     (mode_i[i]),
                .claim_i    (claim_i[i]),
                .complete_i (complete_i[i]),
                .ovf_clr_i  (ovf_clr_i[i]),
                .ip_o       (ip_o[i]),
                .ia_o       (ia_o[i]),
                .ovf_o      (ovf_o[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_plic_gateway_v2.sv
// Directed bench: a 64-source / 2-stage-sync gateway and an 8-source,
// CNT_W=2, unsynchronised gateway sharing clock and reset.
module tb_plic_gateway_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [63:0]      src, claim, complete, ovf_clr, ip, ia, ovf;
    logic [63:0][1:0] mode;
    logic [7:0]       src2, claim2, complete2, ovf_clr2, ip2, ia2, ovf2;
    logic [7:0][1:0]  mode2;

    int checks = 0;
    int errors = 0;

    plic_gateway_v2 #(.N_SOURCE(64), .CNT_W(4), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .src_i(src), .mode_i(mode),
        .claim_i(claim), .complete_i(complete), .ovf_clr_i(ovf_clr),
        .ip_o(ip), .ia_o(ia), .ovf_o(ovf)
    );

    plic_gateway_v2 #(.N_SOURCE(8), .CNT_W(2), .SYNC_STAGES(0)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .src_i(src2), .mode_i(mode2),
        .claim_i(claim2), .complete_i(complete2), .ovf_clr_i(ovf_clr2),
        .ip_o(ip2), .ia_o(ia2), .ovf_o(ovf2)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        src = '0; claim = '0; complete = '0; ovf_clr = '0; mode = '0;
        src2 = '0; claim2 = '0; complete2 = '0; ovf_clr2 = '0; mode2 = '0;
        mode[7]  = 2'b10;   // edge-count
        mode[9]  = 2'b01;   // edge
        mode[11] = 2'b11;   // reserved -> level
        mode2[0] = 2'b10;   // edge-count, CNT_W=2
        tick(2);
        chk("rst_ip",   ip,        64'h0);
        chk("rst_ia",   ia,        64'h0);
        chk("rst_ovf",  ovf,       64'h0);
        chk("rst_ip2",  64'(ip2),  64'h0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_ip",  ip,        64'h0);

        // Level source 5: SYNC_STAGES+1 latency, claim, drop, complete.
        src[5] = 1'b1;
        tick(2);
        chk("lvl_lat_early", ip, 64'h0);
        tick();
        chk("lvl_lat",  ip, 64'h20);
        claim[5] = 1'b1; tick(); claim[5] = 1'b0;
        chk("lvl_claim_ip", ip, 64'h0);
        chk("lvl_claim_ia", ia, 64'h20);
        src[5] = 1'b0;
        tick(3);
        chk("lvl_serv_hold", ia, 64'h20);
        complete[5] = 1'b1; tick(); complete[5] = 1'b0;
        chk("lvl_cmpl_ia", ia, 64'h0);
        tick(3);
        chk("lvl_stay_idle", ip, 64'h0);

        // Level PEND survives source drop; spurious complete in PEND ignored.
        src[5] = 1'b1; tick(3); src[5] = 1'b0;
        tick(4);
        chk("lvl_pend_sticky", ip, 64'h20);
        complete[5] = 1'b1; tick(); complete[5] = 1'b0;
        chk("spur_cmpl_ip", ip, 64'h20);
        chk("spur_cmpl_ia", ia, 64'h0);
        claim[5] = 1'b1; complete[5] = 1'b1; tick(); claim[5] = 1'b0; complete[5] = 1'b0;
        chk("both_pend_ia", ia, 64'h20);
        chk("both_pend_ip", ip, 64'h0);
        complete[5] = 1'b1; tick(); complete[5] = 1'b0;
        tick(2);
        claim[5] = 1'b1; tick(); claim[5] = 1'b0;
        chk("spur_claim_ip", ip, 64'h0);
        chk("spur_claim_ia", ia, 64'h0);

        // Reserved mode code behaves as level.
        src[11] = 1'b1; tick(3);
        chk("mode11_lvl", ip, 64'h800);
        claim[11] = 1'b1; tick(); claim[11] = 1'b0; src[11] = 1'b0;
        tick(3);
        complete[11] = 1'b1; tick(); complete[11] = 1'b0;
        tick(2);
        chk("mode11_done", ip | ia, 64'h0);

        // Edge-count source 7: three pulses -> three services.
        for (int p = 0; p < 3; p++) begin
            src[7] = 1'b1; tick(2); src[7] = 1'b0; tick(2);
        end
        tick(2);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("ecnt_round%0d_ip", r), ip, 64'h80);
            claim[7] = 1'b1; tick(); claim[7] = 1'b0;
            chk($sformatf("ecnt_round%0d_ia", r), ia, 64'h80);
            complete[7] = 1'b1; tick(); complete[7] = 1'b0;
            chk($sformatf("ecnt_round%0d_idle", r), ip | ia, 64'h0);
            tick();
        end
        tick(2);
        chk("ecnt_drained", ip | ia, 64'h0);
        chk("ecnt_no_ovf", ovf, 64'h0);

        // Edge source 9: rise coincident with claim keeps one edge queued.
        src[9] = 1'b1; tick(2); src[9] = 1'b0; tick(2);
        chk("edge_pend", ip, 64'h200);
        src[9] = 1'b1; tick(2);
        claim[9] = 1'b1; tick(); claim[9] = 1'b0;
        chk("edge_coinc_ia", ia, 64'h200);
        chk("edge_coinc_ip", ip, 64'h0);
        src[9] = 1'b0; tick(3);
        complete[9] = 1'b1; tick(); complete[9] = 1'b0;
        chk("edge_cmpl_idle", ip | ia, 64'h0);
        tick();
        chk("edge_repend", ip, 64'h200);
        claim[9] = 1'b1; tick(); claim[9] = 1'b0;
        complete[9] = 1'b1; tick(); complete[9] = 1'b0;
        tick(2);
        chk("edge_drained", ip | ia, 64'h0);

        // Edge mode merges a second edge silently (no overflow).
        for (int p = 0; p < 2; p++) begin
            src[9] = 1'b1; tick(2); src[9] = 1'b0; tick(2);
        end
        chk("edge_merge_ovf", ovf, 64'h0);
        claim[9] = 1'b1; tick(); claim[9] = 1'b0;
        complete[9] = 1'b1; tick(); complete[9] = 1'b0;
        tick(2);
        chk("edge_merge_one", ip | ia, 64'h0);

        // Unsynchronised level: one-cycle latency.
        src2[1] = 1'b1; tick();
        chk("bypass_lat", 64'(ip2), 64'h02);
        claim2[1] = 1'b1; tick(); claim2[1] = 1'b0;
        chk("bypass_claim", 64'(ia2), 64'h02);
        src2[1] = 1'b0;
        complete2[1] = 1'b1; tick(); complete2[1] = 1'b0;
        tick();
        chk("bypass_done", 64'(ip2 | ia2), 64'h0);

        // Edge-count CNT_W=2: saturation at 3, sticky overflow, set-wins.
        for (int p = 0; p < 3; p++) begin
            src2[0] = 1'b1; tick(); src2[0] = 1'b0; tick();
        end
        chk("sat_at_lim_ovf", 64'(ovf2), 64'h0);
        chk("sat_pend", 64'(ip2), 64'h01);
        for (int p = 0; p < 2; p++) begin
            src2[0] = 1'b1; tick(); src2[0] = 1'b0; tick();
        end
        chk("sat_ovf_set", 64'(ovf2), 64'h01);
        tick(2);
        chk("sat_ovf_sticky", 64'(ovf2), 64'h01);
        ovf_clr2[0] = 1'b1; tick(); ovf_clr2[0] = 1'b0;
        chk("ovf_clr", 64'(ovf2), 64'h0);
        src2[0] = 1'b1; ovf_clr2[0] = 1'b1; tick(); src2[0] = 1'b0; ovf_clr2[0] = 1'b0;
        chk("ovf_set_wins", 64'(ovf2), 64'h01);
        tick();
        ovf_clr2[0] = 1'b1; tick(); ovf_clr2[0] = 1'b0;
        chk("ovf_clr2", 64'(ovf2), 64'h0);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("sat_round%0d_ip", r), 64'(ip2), 64'h01);
            claim2[0] = 1'b1; tick(); claim2[0] = 1'b0;
            chk($sformatf("sat_round%0d_ia", r), 64'(ia2), 64'h01);
            complete2[0] = 1'b1; tick(); complete2[0] = 1'b0;
            tick();
        end
        tick(2);
        chk("sat_three_only", 64'(ip2 | ia2), 64'h0);

        // Reset mid-service on source 63 with counted edges on source 7.
        src[63] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            src[7] = 1'b1; tick(2); src[7] = 1'b0; tick(2);
        end
        claim[63] = 1'b1; tick(); claim[63] = 1'b0;
        chk("pre_rst_ia", ia, 64'h8000_0000_0000_0000);
        chk("pre_rst_ip", ip, 64'h80);
        #2;
        rst_n = 1'b0;
        src = '0;
        #1;
        chk("async_rst_ip",  ip,  64'h0);
        chk("async_rst_ia",  ia,  64'h0);
        chk("async_rst_ovf", ovf, 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_ip",  ip,  64'h0);
        chk("post_rst_ia",  ia,  64'h0);
        chk("post_rst_ovf", ovf, 64'h0);
        chk("post_rst_ip2", 64'(ip2 | ia2 | ovf2), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
